key_conditioner: RTL and testbench

Front-end conditioner for the stopwatch push-button. Sits directly upstream of the run/stop state block. It synchronises the raw active-low `key0_in` pin and debounces it with a 4-state FSM. It emits single-cycle press, release and long-press pulses, so the state block toggles `run_stop` exactly once per physical press and can use the long-press pulse as a clear request.

---
 rtl/key_conditioner.sv | 139 +++++++++++++
 tb/tb_key_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button synchroniser, debouncer and press/release/long-press pulse generator
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous active-low reset
//   key0_in      raw button pin, asynchronous to clk, 0 = pressed
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   key_long     one-cycle pulse once per press when the hold time reaches LONG_CYCLES
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key0_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HL_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HL_W-1:0] HL_LAST = HL_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } state_t;

    logic            s1_q, s2_q;
    logic            key_sync;
    state_t          state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [HL_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            long_done_q, long_done_d;
    logic            key_level_q, key_level_d;
    logic            key_press_q, key_press_d;
    logic            key_release_q, key_release_d;
    logic            key_long_q, key_long_d;

    assign key_sync = s2_q;

    always_comb begin
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        long_done_d   = long_done_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        key_long_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!key_sync) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_sync) begin
                    // bounce: the level did not stay low long enough
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                    key_press_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (key_sync) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = '0;
                end else if (!long_done_q && hold_cnt_q == HL_LAST) begin
                    // hold_cnt saturates here; long_done blocks a second pulse
                    key_long_d  = 1'b1;
                    long_done_d = 1'b1;
                end else if (!long_done_q) begin
                    hold_cnt_d = hold_cnt_q + HL_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_sync) begin
                    // release bounce: resume the hold, keeping hold time and long flag
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = ST_IDLE;
                    key_release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        key_level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            state_q       <= ST_IDLE;
            db_cnt_q      <= '0;
            hold_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            key_level_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_long_q    <= 1'b0;
        end else begin
            s1_q          <= key0_in;
            s2_q          <= s1_q;
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            long_done_q   <= long_done_d;
            key_level_q   <= key_level_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_long_q    <= key_long_d;
        end
    end

    assign key_level   = key_level_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_long    = key_long_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

    localparam int D = 4;
    localparam int L = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key0_in = 1'b1;
    logic key_level, key_press, key_release, key_long;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key0_in(key0_in),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int press_cnt = 0, release_cnt = 0, long_cnt = 0, level_cycles = 0, alt_err = 0;
    int press_edge = -1, release_edge = -1, long_edge = -1;
    bit last_was_press = 1'b0;

    always @(negedge clk) begin
        if (key_press) begin
            press_cnt++;
            press_edge = cyc;
            if (last_was_press) alt_err++;
            last_was_press = 1'b1;
        end
        if (key_release) begin
            release_cnt++;
            release_edge = cyc;
            if (!last_was_press) alt_err++;
            last_was_press = 1'b0;
        end
        if (key_long) begin
            long_cnt++;
            long_edge = cyc;
        end
        if (key_level) level_cycles++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k, r, p0, r0, l0, lv0, a0;

    task automatic snap();
        p0  = press_cnt;
        r0  = release_cnt;
        l0  = long_cnt;
        lv0 = level_cycles;
    endtask

    initial begin
        // reset state
        idle(3);
        chk("rst_level", int'(key_level), 0);
        chk("rst_press", int'(key_press), 0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_long", int'(key_long), 0);
        rst = 1'b1;
        idle(5);

        // clean press: 40 cycles low
        snap();
        key0_in = 1'b0;
        k = cyc + 1;
        idle(40);
        key0_in = 1'b1;
        r = cyc + 1;
        idle(20);
        chk("clean_press_cnt", press_cnt - p0, 1);
        chk("clean_press_edge", press_edge - k, D + 2);
        chk("clean_long_cnt", long_cnt - l0, 1);
        chk("clean_long_edge", long_edge - k, D + 2 + L);
        chk("clean_release_cnt", release_cnt - r0, 1);
        chk("clean_release_edge", release_edge - r, D + 2);
        chk("clean_level_cycles", level_cycles - lv0, 40);

        // press bounce: low 3, high 1, low 3, high
        snap();
        key0_in = 1'b0; idle(3);
        key0_in = 1'b1; idle(1);
        key0_in = 1'b0; idle(3);
        key0_in = 1'b1; idle(20);
        chk("bounce_press_cnt", press_cnt - p0, 0);
        chk("bounce_level_cycles", level_cycles - lv0, 0);

        // release bounce: low 12, high 2, low 2, then high
        snap();
        key0_in = 1'b0; k = cyc + 1; idle(12);
        key0_in = 1'b1; idle(2);
        key0_in = 1'b0; idle(2);
        key0_in = 1'b1; r = cyc + 1; idle(20);
        chk("rbounce_press_cnt", press_cnt - p0, 1);
        chk("rbounce_release_cnt", release_cnt - r0, 1);
        chk("rbounce_release_edge", release_edge - r, D + 2);
        chk("rbounce_long_cnt", long_cnt - l0, 0);
        chk("rbounce_level_cycles", level_cycles - lv0, 16);

        // short press: 10 cycles low
        snap();
        key0_in = 1'b0; k = cyc + 1; idle(10);
        key0_in = 1'b1; r = cyc + 1; idle(20);
        chk("short_press_cnt", press_cnt - p0, 1);
        chk("short_release_cnt", release_cnt - r0, 1);
        chk("short_release_edge", release_edge - r, D + 2);
        chk("short_long_cnt", long_cnt - l0, 0);

        // reset while held
        key0_in = 1'b0; idle(12);
        chk("held_level_before_rst", int'(key_level), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_level", int'(key_level), 0);
        chk("async_rst_press", int'(key_press), 0);
        chk("async_rst_release", int'(key_release), 0);
        chk("async_rst_long", int'(key_long), 0);
        idle(1);
        snap();
        rst = 1'b1;
        k = cyc + 1;
        idle(10);
        chk("rerst_press_cnt", press_cnt - p0, 1);
        chk("rerst_press_edge", press_edge - k, D + 2);
        key0_in = 1'b1; idle(20);

        // five presses of 10 cycles spaced by 12
        snap();
        a0 = alt_err;
        for (int i = 0; i < 5; i++) begin
            key0_in = 1'b0; idle(10);
            key0_in = 1'b1; idle(12);
        end
        idle(10);
        chk("repeat_press_cnt", press_cnt - p0, 5);
        chk("repeat_release_cnt", release_cnt - r0, 5);
        chk("repeat_alternation_errs", alt_err - a0, 0);
        chk("repeat_long_cnt", long_cnt - l0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
